// File: rtl/if_stage_if.sv
// Bundle of the fetch-stage controls, instruction-memory data and IF/ID outputs.
// The hazard detector, ID stage and instruction memory drive through "master".
// The fetch stage connects through "slave".
interface if_stage_if #(
    parameter int STALL_CNT_W = 16
);
    logic                   start_i;
    logic                   pc_write_i;
    logic                   ifid_write_i;
    logic                   branch_taken_i;
    logic [31:0]            branch_target_i;
    logic                   jump_i;
    logic [31:0]            jump_target_i;
    logic [31:0]            inst_i;
    logic [31:0]            pc_o;
    logic [31:0]            ifid_pc4_o;
    logic [31:0]            ifid_inst_o;
    logic                   ifid_valid_o;
    logic [STALL_CNT_W-1:0] stall_cnt_o;

    modport slave (
        input  start_i, pc_write_i, ifid_write_i,
        input  branch_taken_i, branch_target_i, jump_i, jump_target_i,
        input  inst_i,
        output pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o, stall_cnt_o
    );

    modport master (
        output start_i, pc_write_i, ifid_write_i,
        output branch_taken_i, branch_target_i, jump_i, jump_target_i,
        output inst_i,
        input  pc_o, ifid_pc4_o, ifid_inst_o, ifid_valid_o, stall_cnt_o
    );
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC register, next-PC select (sequential, branch,
// jump), IF/ID pipeline register and a saturating stall-cycle counter.
// There is no valid/ready handshake here: the hazard detector's pc_write_i and
// ifid_write_i are plain enables sampled on each rising edge while start_i is
// high, and every output is a register.
module if_stage #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter logic [31:0] NOP_INST    = 32'h0000_0000,
    parameter int          STALL_CNT_W = 16
) (
    input  logic        clk_i,
    input  logic        rst_i,
    if_stage_if.slave   bus
);

    logic [31:0]            pc_q,        pc_d;
    logic [31:0]            ifid_pc4_q,  ifid_pc4_d;
    logic [31:0]            ifid_inst_q, ifid_inst_d;
    logic                   ifid_valid_q, ifid_valid_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic        redirect;
    logic [31:0] pc_plus4;
    logic [31:0] next_pc;

    // Next-PC select (branch beats jump; targets word-aligned) and next-state.
    always_comb begin
        redirect = bus.branch_taken_i | bus.jump_i;
        pc_plus4 = pc_q + 32'd4;

        if (bus.branch_taken_i) begin
            next_pc = {bus.branch_target_i[31:2], 2'b00};
        end else if (bus.jump_i) begin
            next_pc = {bus.jump_target_i[31:2], 2'b00};
        end else begin
            next_pc = pc_plus4;
        end

        pc_d         = pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_inst_d  = ifid_inst_q;
        ifid_valid_d = ifid_valid_q;
        stall_cnt_d  = stall_cnt_q;

        if (bus.start_i) begin
            // A held PC is a stall cycle; the redirect is dropped because the
            // branch still sits in ID and will resolve again after the stall.
            if (bus.pc_write_i) begin
                pc_d = next_pc;
            end else if (stall_cnt_q != {STALL_CNT_W{1'b1}}) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end

            if (bus.ifid_write_i) begin
                ifid_pc4_d = pc_plus4;
                // The wrong-path instruction is squashed only when the PC
                // really moves to the target this edge.
                if (redirect && bus.pc_write_i) begin
                    ifid_inst_d  = NOP_INST;
                    ifid_valid_d = 1'b0;
                end else begin
                    ifid_inst_d  = bus.inst_i;
                    ifid_valid_d = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pc_q         <= RESET_PC;
            ifid_pc4_q   <= 32'd0;
            ifid_inst_q  <= NOP_INST;
            ifid_valid_q <= 1'b0;
            stall_cnt_q  <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_inst_q  <= ifid_inst_d;
            ifid_valid_q <= ifid_valid_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign bus.pc_o         = pc_q;
    assign bus.ifid_pc4_o   = ifid_pc4_q;
    assign bus.ifid_inst_o  = ifid_inst_q;
    assign bus.ifid_valid_o = ifid_valid_q;
    assign bus.stall_cnt_o  = stall_cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: a vector table replayed through a scoreboard queue, plus
// hand-written reset-mid-stall and start_i=0 sequences. A second instance with
// a 2-bit stall counter shares the stimulus to exercise saturation.
module tb_if_stage;

    localparam logic [31:0] KEY = 32'hC0DE_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] inst;
        logic        valid;
        logic [15:0] stall;
        logic [1:0]  stall2;
    } out_t;

    typedef struct packed {
        logic        start;
        logic        pcw;
        logic        ifw;
        logic        br;
        logic [31:0] btgt;
        logic        jmp;
        logic [31:0] jtgt;
        out_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    out_t exp_q[$];
    int   n_vec = 0;
    int   n_bad = 0;

    if_stage_if #(.STALL_CNT_W(16)) bus  ();
    if_stage_if #(.STALL_CNT_W(2))  bus2 ();

    if_stage #(.STALL_CNT_W(16)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    if_stage #(.STALL_CNT_W(2)) dut2 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus2)
    );

    // Instruction memory model: word derived from the address it is read at.
    assign bus.inst_i  = bus.pc_o  ^ KEY;
    assign bus2.inst_i = bus2.pc_o ^ KEY;

    assign bus2.start_i         = bus.start_i;
    assign bus2.pc_write_i      = bus.pc_write_i;
    assign bus2.ifid_write_i    = bus.ifid_write_i;
    assign bus2.branch_taken_i  = bus.branch_taken_i;
    assign bus2.branch_target_i = bus.branch_target_i;
    assign bus2.jump_i          = bus.jump_i;
    assign bus2.jump_target_i   = bus.jump_target_i;

    // Clock.
    always #5 clk = ~clk;

    function automatic out_t actual();
        out_t a;
        a.pc     = bus.pc_o;
        a.pc4    = bus.ifid_pc4_o;
        a.inst   = bus.ifid_inst_o;
        a.valid  = bus.ifid_valid_o;
        a.stall  = bus.stall_cnt_o;
        a.stall2 = bus2.stall_cnt_o;
        return a;
    endfunction

    function automatic out_t mk_out(input logic [31:0] pc, input logic [31:0] pc4,
                                    input logic [31:0] inst, input logic valid,
                                    input logic [15:0] stall, input logic [1:0] stall2);
        out_t o;
        o.pc = pc; o.pc4 = pc4; o.inst = inst; o.valid = valid;
        o.stall = stall; o.stall2 = stall2;
        return o;
    endfunction

    function automatic vec_t mk_vec(input logic start, input logic pcw, input logic ifw,
                                    input logic br, input logic [31:0] btgt,
                                    input logic jmp, input logic [31:0] jtgt,
                                    input out_t exp);
        vec_t v;
        v.start = start; v.pcw = pcw; v.ifw = ifw; v.br = br; v.btgt = btgt;
        v.jmp = jmp; v.jtgt = jtgt; v.exp = exp;
        return v;
    endfunction

    task automatic check(input string name, input out_t exp);
        out_t act;
        act = actual();
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got pc=%h pc4=%h inst=%h valid=%b stall=%0d stall2=%0d, want pc=%h pc4=%h inst=%h valid=%b stall=%0d stall2=%0d",
                     name, act.pc, act.pc4, act.inst, act.valid, act.stall, act.stall2,
                     exp.pc, exp.pc4, exp.inst, exp.valid, exp.stall, exp.stall2);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.start_i         = v.start;
        bus.pc_write_i      = v.pcw;
        bus.ifid_write_i    = v.ifw;
        bus.branch_taken_i  = v.br;
        bus.branch_target_i = v.btgt;
        bus.jump_i          = v.jmp;
        bus.jump_target_i   = v.jtgt;
    endtask

    vec_t vecs[18];

    initial begin
        out_t exp_o;
        vec_t idle;

        // start, pcw, ifw, br, btgt, jmp, jtgt -> pc, ifid_pc4, ifid_inst, valid, stall, stall2
        vecs[0]  = mk_vec(1,1,1, 0,0, 0,0, mk_out(32'h4,   32'h4,   32'h0^KEY,   1, 0, 0));
        vecs[1]  = mk_vec(1,1,1, 0,0, 0,0, mk_out(32'h8,   32'h8,   32'h4^KEY,   1, 0, 0));
        vecs[2]  = mk_vec(1,0,0, 0,0, 0,0, mk_out(32'h8,   32'h8,   32'h4^KEY,   1, 1, 1));
        vecs[3]  = mk_vec(1,0,0, 0,0, 0,0, mk_out(32'h8,   32'h8,   32'h4^KEY,   1, 2, 2));
        vecs[4]  = mk_vec(1,1,1, 0,0, 0,0, mk_out(32'hC,   32'hC,   32'h8^KEY,   1, 2, 2));
        vecs[5]  = mk_vec(1,1,1, 0,0, 0,0, mk_out(32'h10,  32'h10,  32'hC^KEY,   1, 2, 2));
        vecs[6]  = mk_vec(1,1,1, 1,32'h103, 0,0, mk_out(32'h100, 32'h14, 32'h0, 0, 2, 2));
        vecs[7]  = mk_vec(1,1,1, 0,0, 0,0, mk_out(32'h104, 32'h104, 32'h100^KEY, 1, 2, 2));
        vecs[8]  = mk_vec(1,1,1, 1,32'h40, 1,32'h80, mk_out(32'h40, 32'h108, 32'h0, 0, 2, 2));
        vecs[9]  = mk_vec(1,1,1, 0,0, 1,32'h83, mk_out(32'h80, 32'h44, 32'h0, 0, 2, 2));
        vecs[10] = mk_vec(1,0,0, 1,32'h200, 0,0, mk_out(32'h80, 32'h44, 32'h0, 0, 3, 3));
        vecs[11] = mk_vec(1,0,1, 1,32'h200, 0,0, mk_out(32'h80, 32'h84, 32'h80^KEY, 1, 4, 3));
        vecs[12] = mk_vec(1,1,0, 0,0, 0,0, mk_out(32'h84,  32'h84,  32'h80^KEY,  1, 4, 3));
        vecs[13] = mk_vec(0,0,1, 0,0, 1,32'h300, mk_out(32'h84, 32'h84, 32'h80^KEY, 1, 4, 3));
        vecs[14] = mk_vec(1,1,1, 0,0, 0,0, mk_out(32'h88,  32'h88,  32'h84^KEY,  1, 4, 3));
        vecs[15] = mk_vec(1,1,1, 0,0, 1,32'hFFFF_FFFF, mk_out(32'hFFFF_FFFC, 32'h8C, 32'h0, 0, 4, 3));
        vecs[16] = mk_vec(1,1,1, 0,0, 0,0, mk_out(32'h0,   32'h0,   32'hFFFF_FFFC^KEY, 1, 4, 3));
        vecs[17] = mk_vec(1,0,0, 0,0, 0,0, mk_out(32'h0,   32'h0,   32'hFFFF_FFFC^KEY, 1, 5, 3));

        idle = mk_vec(0,1,1, 0,0, 0,0, '0);
        drive(idle);

        // Reset state while rst is held.
        repeat (2) @(posedge clk);
        #1 check("reset_hold", mk_out(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b0;

        // Table replay through the scoreboard.
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            exp_q.push_back(vecs[i].exp);
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL scoreboard_empty: got empty queue, want entry at vector %0d", i);
            end else begin
                exp_o = exp_q.pop_front();
                check($sformatf("vec%0d", i), exp_o);
            end
        end

        // Reset asserted between edges during a stall: outputs clear at once.
        @(negedge clk);
        drive(mk_vec(1,0,0, 0,0, 0,0, '0));
        @(posedge clk);
        #2 rst = 1'b1;
        #1 check("reset_mid_stall", mk_out(0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1 check("reset_across_edge", mk_out(0, 0, 0, 0, 0, 0));

        // start_i low with a redirect pending: nothing moves.
        @(negedge clk);
        rst = 1'b0;
        drive(mk_vec(0,1,1, 1,32'h500, 1,32'h600, '0));
        @(posedge clk);
        #1 check("start_low_redirect", mk_out(0, 0, 0, 0, 0, 0));

        // First run edge after reset: fetch resumes from RESET_PC.
        @(negedge clk);
        drive(mk_vec(1,1,1, 0,0, 0,0, '0));
        @(posedge clk);
        #1 check("restart_seq", mk_out(32'h4, 32'h4, 32'h0^KEY, 1, 0, 0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #100000;
        $display("FAIL timeout: got no completion, want finish before 100000");
        $fatal(1);
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage pipeline: PC register, next-PC select (sequential, branch, jump) and the IF/ID pipeline register.
- Sits directly upstream of ID and of the load-use hazard detector.
- Consumes the detector's PC-write and IF/ID-write controls plus the ID-stage branch/jump redirect.
- Produces the fetch PC for instruction memory and the IF/ID contents consumed by decode.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0000, instruction word inserted into IF/ID on flush and reset.
- STALL_CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk_i  in  1  single clock; all state on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  pipeline run enable; low = all state held
- pc_write_i  in  1  PC update enable (hazard detector PCWrite)
- ifid_write_i  in  1  IF/ID update enable (hazard detector IFID write)
- branch_taken_i  in  1  ID-stage branch resolved taken
- branch_target_i  in  32  branch target address
- jump_i  in  1  ID-stage jump
- jump_target_i  in  32  jump target address
- inst_i  in  32  instruction memory read data for pc_o (combinational, same cycle)
- pc_o  out  32  current fetch PC
- ifid_pc4_o  out  32  PC+4 of the instruction held in IF/ID
- ifid_inst_o  out  32  instruction held in IF/ID
- ifid_valid_o  out  1  IF/ID holds a real (non-flushed) instruction
- stall_cnt_o  out  STALL_CNT_W  count of stalled cycles since reset

Behaviour:
- Reset (rst_i=1, asynchronous, any time including mid-stall or mid-redirect) sets the following; these hold until first clock edge with rst_i=0:
  - pc_o=RESET_PC
  - ifid_inst_o=NOP_INST
  - ifid_pc4_o=0
  - ifid_valid_o=0
  - stall_cnt_o=0
- start_i=0: no register changes on any edge; redirect and stall inputs ignored.
- Define redirect = branch_taken_i | jump_i.
- Next-PC priority: branch_taken_i → branch_target_i; else jump_i → jump_target_i; else pc_o+4.
  - Both branch_taken_i and jump_i high: branch wins.
- Next-PC arithmetic:
  - pc_o+4 is 32-bit, wraps modulo 2^32 (32'hFFFF_FFFC → 0).
  - Target addresses loaded with bits[1:0] forced to 0.
- PC update, each edge with start_i=1:
  - pc_write_i=1: pc_o ← next-PC.
  - pc_write_i=0: pc_o holds; redirect is ignored this cycle. The branch in ID re-evaluates after the stall, so no redirect is lost.
- IF/ID update, each edge with start_i=1:
  - ifid_write_i=0: all IF/ID outputs hold.
  - ifid_write_i=1 and redirect=1 and pc_write_i=1 (flush):
    - ifid_inst_o ← NOP_INST, ifid_valid_o ← 0
    - ifid_pc4_o ← pc_o+4 (don't-care for decode)
  - ifid_write_i=1 otherwise: ifid_inst_o ← inst_i, ifid_pc4_o ← pc_o+4, ifid_valid_o ← 1.
- pc_write_i and ifid_write_i are independent; any combination is legal and handled per the rules above.
- Latency:
  - Instruction fetched at PC X appears on ifid_inst_o one edge later.
  - A redirect costs exactly one bubble.
- stall_cnt_o:
  - Increments by 1 on each edge with start_i=1 and pc_write_i=0.
  - Saturates at all-ones; no wrap.

Test Plan:
- Reset release, start_i=1, controls 1, inst_i=PC-dependent pattern → pc_o 0,4,8,12 on successive edges; ifid_pc4_o trails 4,8,12; ifid_valid_o=1 from first edge.
- Load-use stall: pc_write_i=ifid_write_i=0 for 2 cycles at pc_o=8 → pc_o, IF/ID hold 2 cycles, stall_cnt_o=2, then sequence resumes at 12.
- Branch taken at pc_o=16, branch_target_i=32'h0000_0103 → next pc_o=32'h100; IF/ID=NOP_INST, valid=0; following edge fetches 0x100 with valid=1.
- branch_taken_i=1 and jump_i=1 together (branch 0x40, jump 0x80) → pc_o=0x40. Redirect with pc_write_i=0 → pc_o and IF/ID unchanged.
- pc_o=32'hFFFF_FFFC sequential → pc_o=0, ifid_pc4_o=0. With STALL_CNT_W=2, 5 stall cycles → stall_cnt_o=3.
- rst_i asserted mid-stall between edges → outputs reset immediately; start_i=0 with redirect → no change.
